// File: rtl/ps2_mouse_packet_ctrl_pkg.sv
// rtl/ps2_mouse_packet_ctrl_pkg.sv - shared encodings and constants for the PS/2 mouse packet controller
package ps2_mouse_packet_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_INIT_SEND = 3'd0,
        ST_INIT_ACK  = 3'd1,
        ST_BYTE0     = 3'd2,
        ST_BYTE1     = 3'd3,
        ST_BYTE2     = 3'd4
    } state_e;

    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic [7:0] MOUSE_ACK  = 8'hFA;

    // Bit positions inside packet byte 0
    localparam int SYNC  = 3;
    localparam int XSIGN = 4;
    localparam int YSIGN = 5;
    localparam int XOVF  = 6;
    localparam int YOVF  = 7;

endpackage

// File: rtl/ps2_mouse_packet_ctrl_timeout_counter.sv
// rtl/ps2_mouse_packet_ctrl_timeout_counter.sv - saturating inter-byte / ACK-wait timer
module ps2_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count_q;

    assign expired = (count_q == LIMIT);

    // Count up while enabled and hold at the limit so the timer never wraps
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ps2_mouse_packet_ctrl.sv
// rtl/ps2_mouse_packet_ctrl.sv - PS/2 mouse init sequencer and 3-byte stream packet decoder
module ps2_mouse_packet_ctrl
    import ps2_mouse_packet_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2_500_000,
    parameter int RETRY_MAX      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    input  logic       tx_ready,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic [8:0] x_delta,
    output logic [8:0] y_delta,
    output logic [2:0] buttons,
    output logic       data_ready,
    output logic       sync_error,
    output logic       init_done,
    output logic       init_fail
);

    localparam int RW = $clog2(RETRY_MAX + 1);

    state_e        state_q, state_d;
    logic [RW-1:0] retry_q;
    logic [6:0]    hdr_q;      // byte 0 without the sync bit: {yovf, xovf, ysign, xsign, buttons}
    logic [7:0]    byte1_q;
    logic          tx_start_q, data_ready_q, sync_error_q, init_done_q, init_fail_q;
    logic [7:0]    tx_data_q;
    logic [8:0]    x_delta_q, y_delta_q;
    logic [2:0]    buttons_q;

    logic send, tmr_clear, tmr_en, tmr_expired;
    logic lat0, lat1, pkt_done, sync_err, ack, fail;

    ps2_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear),
        .enable  (tmr_en),
        .expired (tmr_expired)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_INIT_SEND;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-cycle control; a byte in the same cycle as expiry wins
    always_comb begin
        state_d   = state_q;
        send      = 1'b0;
        tmr_clear = 1'b0;
        tmr_en    = 1'b0;
        lat0      = 1'b0;
        lat1      = 1'b0;
        pkt_done  = 1'b0;
        sync_err  = 1'b0;
        ack       = 1'b0;
        fail      = 1'b0;
        case (state_q)
            ST_INIT_SEND: begin
                if (tx_ready) begin
                    send      = 1'b1;
                    tmr_clear = 1'b1;
                    state_d   = ST_INIT_ACK;
                end
            end
            ST_INIT_ACK: begin
                tmr_en = 1'b1;
                if (byte_valid && byte_data == MOUSE_ACK) begin
                    ack     = 1'b1;
                    state_d = ST_BYTE0;
                end else if (tmr_expired) begin
                    if (retry_q < RW'(RETRY_MAX)) begin
                        state_d = ST_INIT_SEND;
                    end else begin
                        fail    = 1'b1;
                        state_d = ST_BYTE0;
                    end
                end
            end
            ST_BYTE0: begin
                if (byte_valid) begin
                    if (byte_data[SYNC]) begin
                        lat0      = 1'b1;
                        tmr_clear = 1'b1;
                        state_d   = ST_BYTE1;
                    end else begin
                        sync_err = 1'b1;
                    end
                end
            end
            ST_BYTE1: begin
                tmr_en = 1'b1;
                if (byte_valid) begin
                    lat1      = 1'b1;
                    tmr_clear = 1'b1;
                    state_d   = ST_BYTE2;
                end else if (tmr_expired) begin
                    state_d = ST_BYTE0;
                end
            end
            ST_BYTE2: begin
                tmr_en = 1'b1;
                if (byte_valid) begin
                    pkt_done = 1'b1;
                    state_d  = ST_BYTE0;
                end else if (tmr_expired) begin
                    state_d = ST_BYTE0;
                end
            end
            default: state_d = ST_INIT_SEND;
        endcase
    end

    // Strobes, status flags, byte latches and the packet output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            retry_q      <= '0;
            data_ready_q <= 1'b0;
            sync_error_q <= 1'b0;
            init_done_q  <= 1'b0;
            init_fail_q  <= 1'b0;
            hdr_q        <= '0;
            byte1_q      <= '0;
            x_delta_q    <= '0;
            y_delta_q    <= '0;
            buttons_q    <= '0;
        end else begin
            tx_start_q   <= send;
            data_ready_q <= pkt_done;
            sync_error_q <= sync_err;
            if (send) begin
                tx_data_q <= CMD_ENABLE;
                retry_q   <= retry_q + RW'(1);
            end
            if (ack) begin
                init_done_q <= 1'b1;
            end
            if (fail) begin
                init_fail_q <= 1'b1;
            end
            if (lat0) begin
                hdr_q <= {byte_data[7:4], byte_data[2:0]};
            end
            if (lat1) begin
                byte1_q <= byte_data;
            end
            if (pkt_done) begin
                x_delta_q <= hdr_q[XOVF-1] ? 9'd0 : {hdr_q[XSIGN-1], byte1_q};
                y_delta_q <= hdr_q[YOVF-1] ? 9'd0 : {hdr_q[YSIGN-1], byte_data};
                buttons_q <= hdr_q[2:0];
            end
        end
    end

    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign x_delta    = x_delta_q;
    assign y_delta    = y_delta_q;
    assign buttons    = buttons_q;
    assign data_ready = data_ready_q;
    assign sync_error = sync_error_q;
    assign init_done  = init_done_q;
    assign init_fail  = init_fail_q;

endmodule

// File: tb/tb_ps2_mouse_packet_ctrl.sv
// tb/tb_ps2_mouse_packet_ctrl.sv - scoreboard bench for the PS/2 mouse packet controller
module tb_ps2_mouse_packet_ctrl;

    localparam int TO = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       tx_ready = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [8:0] x_delta, y_delta;
    logic [2:0] buttons;
    logic       data_ready, sync_error, init_done, init_fail;

    ps2_mouse_packet_ctrl #(.TIMEOUT_CYCLES(TO), .RETRY_MAX(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .tx_ready   (tx_ready),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .x_delta    (x_delta),
        .y_delta    (y_delta),
        .buttons    (buttons),
        .data_ready (data_ready),
        .sync_error (sync_error),
        .init_done  (init_done),
        .init_fail  (init_fail)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [8:0] x;
        logic [8:0] y;
        logic [2:0] b;
        int         at;
    } pkt_t;

    pkt_t exp_q[$];
    pkt_t p;
    int   tx_expect = 0;
    int   tx_seen = 0;
    int   sync_expect = 0;
    int   last_tx = -1;
    int   checks = 0;
    int   fails = 0;

    // Monitor: compares every DUT output event against the scoreboard
    always @(negedge clk) begin
        if (data_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_data_ready: got x=%h y=%h b=%b at cycle %0d, required no strobe",
                         x_delta, y_delta, buttons, cyc);
            end else begin
                p = exp_q.pop_front();
                if (x_delta !== p.x || y_delta !== p.y || buttons !== p.b || cyc != p.at) begin
                    fails++;
                    $display("FAIL packet: got x=%h y=%h b=%b cyc=%0d, required x=%h y=%h b=%b cyc=%0d",
                             x_delta, y_delta, buttons, cyc, p.x, p.y, p.b, p.at);
                end
            end
        end
        if (tx_start) begin
            tx_seen++;
            checks++;
            if (tx_expect == 0 || tx_data !== 8'hF4) begin
                fails++;
                $display("FAIL tx_start: got tx_data=%h with %0d pulses expected, required 0xF4 and an expected pulse",
                         tx_data, tx_expect);
            end else begin
                tx_expect--;
            end
            if (last_tx >= 0) begin
                checks++;
                if (cyc - last_tx < TO) begin
                    fails++;
                    $display("FAIL tx_spacing: got %0d cycles, required >= %0d", cyc - last_tx, TO);
                end
            end
            last_tx = cyc;
        end
        if (sync_error) begin
            checks++;
            if (sync_expect == 0) begin
                fails++;
                $display("FAIL unexpected_sync_error: got pulse at cycle %0d, required none", cyc);
            end else begin
                sync_expect--;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_data  = b;
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [8:0] x, input logic [8:0] y, input logic [2:0] b);
        pkt_t e;
        e.x  = x;
        e.y  = y;
        e.b  = b;
        e.at = cyc;
        exp_q.push_back(e);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [8:0] x, input logic [8:0] y, input logic [2:0] b);
        send_byte(b0);
        tick(1);
        send_byte(b1);
        tick(1);
        send_byte(b2);
        push_exp(x, y, b);
        tick(3);
    endtask

    task automatic wait_tx(input int n);
        for (int i = 0; i < 2000 && tx_seen < n; i++) tick(1);
        check("tx_pulse_count", tx_seen, n);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_tx_start"}, {31'd0, tx_start}, 0);
        check({tag, "_tx_data"}, {24'd0, tx_data}, 0);
        check({tag, "_x_delta"}, {23'd0, x_delta}, 0);
        check({tag, "_y_delta"}, {23'd0, y_delta}, 0);
        check({tag, "_buttons"}, {29'd0, buttons}, 0);
        check({tag, "_data_ready"}, {31'd0, data_ready}, 0);
        check({tag, "_sync_error"}, {31'd0, sync_error}, 0);
        check({tag, "_init_done"}, {31'd0, init_done}, 0);
        check({tag, "_init_fail"}, {31'd0, init_fail}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b0;
        tick(3);
        check_cleared("reset");
        rst = 1'b1;
        tick(20);
        check("no_tx_without_ready", tx_seen, 0);

        // Init handshake, non-ACK byte ignored
        tx_expect = 1;
        tx_ready  = 1'b1;
        wait_tx(1);
        tick(5);
        send_byte(8'h55);
        tick(2);
        check("init_done_after_non_ack", {31'd0, init_done}, 0);
        send_byte(8'hFA);
        tick(2);
        check("init_done", {31'd0, init_done}, 1);
        check("init_fail_after_ack", {31'd0, init_fail}, 0);
        check("single_tx_pulse", tx_seen, 1);

        // Packet decode
        send_pkt(8'h39, 8'h05, 8'hFE, 9'h105, 9'h1FE, 3'b001);

        // Sync loss then a good packet
        sync_expect = 1;
        send_byte(8'h00);
        tick(2);
        check("sync_error_seen", sync_expect, 0);
        send_pkt(8'h08, 8'h10, 8'h20, 9'h010, 9'h020, 3'b000);

        // Inter-byte timeout keeps previous outputs, then overflow packet
        send_byte(8'h08);
        tick(1);
        send_byte(8'h10);
        tick(TO + 50);
        check("held_x_after_timeout", {23'd0, x_delta}, 32'h010);
        check("held_y_after_timeout", {23'd0, y_delta}, 32'h020);
        send_pkt(8'h48, 8'h7F, 8'h03, 9'h000, 9'h003, 3'b000);

        // Back-to-back packets: next byte0 lands in the data_ready cycle
        send_byte(8'h18);
        send_byte(8'h01);
        send_byte(8'h02);
        push_exp(9'h101, 9'h002, 3'b000);
        send_byte(8'h0A);
        send_byte(8'h04);
        send_byte(8'h06);
        push_exp(9'h004, 9'h006, 3'b010);
        tick(3);

        // Reset mid-packet, then retries exhaust with no ACK
        send_byte(8'h08);
        tick(1);
        send_byte(8'h10);
        tick(1);
        rst = 1'b0;
        tick(2);
        check_cleared("midreset");
        check("no_pending_packets", exp_q.size(), 0);
        last_tx   = -1;
        tx_seen   = 0;
        tx_expect = 3;
        rst = 1'b1;
        wait_tx(3);
        for (int i = 0; i < 500 && init_fail !== 1'b1; i++) tick(1);
        check("init_fail", {31'd0, init_fail}, 1);
        check("init_done_after_fail", {31'd0, init_done}, 0);
        tick(300);
        check("no_fourth_tx", tx_seen, 3);
        send_pkt(8'h39, 8'h05, 8'hFE, 9'h105, 9'h1FE, 3'b001);

        tick(5);
        check("scoreboard_empty", exp_q.size(), 0);
        check("tx_expect_drained", tx_expect, 0);
        check("sync_expect_drained", sync_expect, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
